// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter.
// Sends one byte using the inhibit / request-to-send / device-clocked frame
// sequence and drives PS2CLK and PS2DAT as open-drain enables.
//
// Ports:
//   CLK, RST      system clock, synchronous active-high reset
//   cmd_data      command byte, captured when cmd_valid && cmd_ready
//   cmd_valid     command request
//   cmd_ready     idle and able to accept a command
//   ps2_clk_in    raw PS2CLK pin level (asynchronous)
//   ps2_dat_in    raw PS2DAT pin level (asynchronous)
//   ps2_clk_oe    1 = pull PS2CLK low
//   ps2_dat_oe    1 = pull PS2DAT low
//   busy          transfer in progress
//   cmd_sent      one-cycle pulse when the device acknowledged
//   err_timeout   one-cycle pulse when a timeout aborted the transfer
//   err_noack     one-cycle pulse when the ACK bit was sampled high
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int START_TIMEOUT  = 750000,
    parameter int XFER_TIMEOUT   = 100000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] cmd_data,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       cmd_sent,
    output logic       err_timeout,
    output logic       err_noack
);

    localparam int MAX_AB = (INHIBIT_CYCLES > START_TIMEOUT) ?
                            INHIBIT_CYCLES : START_TIMEOUT;
    localparam int MAX_P  = (MAX_AB > XFER_TIMEOUT) ? MAX_AB : XFER_TIMEOUT;
    localparam int CW     = $clog2(MAX_P + 1);

    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] ST_LAST  = CW'(START_TIMEOUT - 1);
    localparam logic [CW-1:0] XF_LAST  = CW'(XFER_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_RTS,
        S_WAIT_START,
        S_SHIFT,
        S_WAIT_IDLE,
        S_ABORT
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      idx_q, idx_d;
    logic [7:0]      data_q, data_d;
    logic            par_q, par_d;

    logic            clk_s1_q, clk_s2_q, clk_prev_q;
    logic            dat_s1_q, dat_s2_q;

    logic            ready_q, ready_d;
    logic            busy_q, busy_d;
    logic            clk_oe_q, clk_oe_d;
    logic            dat_oe_q, dat_oe_d;
    logic            sent_q, sent_d;
    logic            tout_q, tout_d;
    logic            noack_q, noack_d;

    logic            clk_fall;
    logic            bit_oe;

    // Synchronizers reset to the idle (released, pulled-up) line level so
    // that leaving reset never looks like a falling edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
        end else begin
            clk_s1_q   <= ps2_clk_in;
            clk_s2_q   <= clk_s1_q;
            clk_prev_q <= clk_s2_q;
            dat_s1_q   <= ps2_dat_in;
            dat_s2_q   <= dat_s1_q;
        end
    end

    assign clk_fall = clk_prev_q & ~clk_s2_q;

    // Open-drain enable for the frame bit selected by idx:
    // 1..7 data, 8 parity, 9 stop (released).
    always_comb begin
        bit_oe = 1'b0;
        if (idx_q == 4'd8) begin
            bit_oe = ~par_q;
        end else if (idx_q < 4'd8) begin
            bit_oe = ~data_q[idx_q[2:0]];
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        data_d   = data_q;
        par_d    = par_q;
        dat_oe_d = 1'b0;
        sent_d   = 1'b0;
        tout_d   = 1'b0;
        noack_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid && ready_q) begin
                    data_d  = cmd_data;
                    par_d   = ~^cmd_data;
                    idx_d   = 4'd0;
                    cnt_d   = '0;
                    state_d = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (cnt_q == INH_LAST) begin
                    cnt_d    = '0;
                    dat_oe_d = 1'b1;
                    state_d  = S_RTS;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RTS: begin
                dat_oe_d = 1'b1;
                state_d  = S_WAIT_START;
            end
            S_WAIT_START: begin
                if (clk_fall) begin
                    dat_oe_d = ~data_q[0];
                    idx_d    = 4'd1;
                    cnt_d    = '0;
                    state_d  = S_SHIFT;
                end else if (cnt_q == ST_LAST) begin
                    tout_d  = 1'b1;
                    state_d = S_ABORT;
                end else begin
                    dat_oe_d = 1'b1;
                    cnt_d    = cnt_q + CW'(1);
                end
            end
            S_SHIFT: begin
                dat_oe_d = dat_oe_q;
                if (cnt_q == XF_LAST) begin
                    dat_oe_d = 1'b0;
                    tout_d   = 1'b1;
                    state_d  = S_ABORT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (clk_fall) begin
                        if (idx_q == 4'd10) begin
                            dat_oe_d = 1'b0;
                            if (dat_s2_q) begin
                                noack_d = 1'b1;
                                state_d = S_ABORT;
                            end else begin
                                state_d = S_WAIT_IDLE;
                            end
                        end else begin
                            dat_oe_d = bit_oe;
                            idx_d    = idx_q + 4'd1;
                        end
                    end
                end
            end
            S_WAIT_IDLE: begin
                if (cnt_q == XF_LAST) begin
                    tout_d  = 1'b1;
                    state_d = S_ABORT;
                end else if (clk_s2_q && dat_s2_q) begin
                    sent_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_ABORT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        clk_oe_d = (state_d == S_INHIBIT) || (state_d == S_RTS);
        busy_d   = (state_d != S_IDLE);
        ready_d  = (state_d == S_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= 4'd0;
            data_q   <= 8'd0;
            par_q    <= 1'b0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
            sent_q   <= 1'b0;
            tout_q   <= 1'b0;
            noack_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
            par_q    <= par_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            clk_oe_q <= clk_oe_d;
            dat_oe_q <= dat_oe_d;
            sent_q   <= sent_d;
            tout_q   <= tout_d;
            noack_q  <= noack_d;
        end
    end

    assign cmd_ready   = ready_q;
    assign busy        = busy_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_dat_oe  = dat_oe_q;
    assign cmd_sent    = sent_q;
    assign err_timeout = tout_q;
    assign err_noack   = noack_q;

endmodule
